// File: rtl/monopix_readout_ctrl.sv
// monopix_readout_ctrl: token readout sequencer for one MONOPIX flavour output.
// Divides clk_out down to the bunch-crossing rate, walks the chip through
// token -> freeze -> read -> serial shift, deserialises one {col,te,le,row}
// word per cycle, optionally Gray-decodes the timestamps and queues the word
// in a small FIFO with a valid/ready interface towards the packet builder.
module monopix_readout_ctrl #(
  parameter int COL_BITS      = 6,
  parameter int TS_BITS       = 6,
  parameter int ROW_BITS      = 9,
  parameter int BX_DIV        = 4,
  parameter int TOKEN_WAIT_BX = 3,
  parameter int READ_BX       = 2,
  parameter int SER_LAT       = 3,
  parameter int GRAY_DECODE   = 1,
  parameter int FIFO_DEPTH    = 8,
  localparam int W            = COL_BITS + 2*TS_BITS + ROW_BITS
) (
  input  logic         clk_out,
  input  logic         reset,
  input  logic         enable,
  input  logic         token,
  input  logic         data_in,
  output logic         read,
  output logic         freeze,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         overflow,
  output logic [15:0]  lost_cnt
);

  localparam int DIV_W  = (BX_DIV > 1) ? $clog2(BX_DIV) : 1;
  localparam int PH_MAX = (TOKEN_WAIT_BX > READ_BX) ? TOKEN_WAIT_BX : READ_BX;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CYC_W  = $clog2(SER_LAT + W + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LE_LSB = ROW_BITS;
  localparam int TE_LSB = ROW_BITS + TS_BITS;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BX_DIV - 1);
  localparam logic [PH_W-1:0]  TW_LAST   = PH_W'(TOKEN_WAIT_BX - 1);
  localparam logic [PH_W-1:0]  RD_LAST   = PH_W'(READ_BX - 1);
  localparam logic [CYC_W-1:0] CYC_FIRST = CYC_W'(SER_LAT);
  localparam logic [CYC_W-1:0] CYC_PUSH  = CYC_W'(SER_LAT + W);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TOKEN_WAIT,
    S_READ,
    S_SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               done_q, done_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic               read_q, read_d;
  logic               freeze_q, freeze_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        lost_cnt_q, lost_cnt_d;
  logic [W-1:0]       mem_q [FIFO_DEPTH];

  logic               bx_tick;
  logic               push_req;
  logic [W-1:0]       push_word;
  logic               pop, full, wr_en, drop;

  function automatic logic [TS_BITS-1:0] gray2bin(input logic [TS_BITS-1:0] g);
    logic [TS_BITS-1:0] b;
    b[TS_BITS-1] = g[TS_BITS-1];
    for (int i = TS_BITS - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign bx_tick = (div_q == DIV_LAST);

  // Sequencer: BX divider, state/phase/cycle counters and serial capture.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    div_d    = bx_tick ? '0 : div_q + DIV_W'(1);
    state_d  = state_q;
    phase_d  = phase_q;
    cyc_d    = cyc_q;
    done_d   = done_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bx_tick && token && enable) state_d = S_TOKEN_WAIT;
      end
      S_TOKEN_WAIT: begin
        if (bx_tick) begin
          if (phase_q == TW_LAST) state_d = S_READ;
          else                    phase_d = phase_q + PH_W'(1);
        end
      end
      S_READ: begin
        if (bx_tick) begin
          if (phase_q == RD_LAST) state_d = S_SHIFT;
          else                    phase_d = phase_q + PH_W'(1);
        end
      end
      S_SHIFT: begin
        if (!done_q) begin
          if (cyc_q >= CYC_FIRST && cyc_q < CYC_PUSH) shreg_d = {shreg_q[W-2:0], data_in};
          if (cyc_q == CYC_PUSH) begin
            push_req = 1'b1;
            done_d   = 1'b1;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        // Leave only once the word has been handed to the FIFO (or dropped).
        if (bx_tick && done_q) state_d = (token && enable) ? S_TOKEN_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      phase_d = '0;
      cyc_d   = '0;
      done_d  = 1'b0;
    end
    read_d   = (state_d == S_READ);
    freeze_d = (state_d == S_TOKEN_WAIT) || (state_d == S_READ);
    busy_d   = (state_d != S_IDLE);
  end

  // Word formatting: optional Gray->binary conversion of the TE and LE fields.
  always_comb begin
    push_word = shreg_q;
    if (GRAY_DECODE != 0) begin
      push_word[TE_LSB +: TS_BITS] = gray2bin(shreg_q[TE_LSB +: TS_BITS]);
      push_word[LE_LSB +: TS_BITS] = gray2bin(shreg_q[LE_LSB +: TS_BITS]);
    end
  end

  // FIFO bookkeeping: a push into a full FIFO survives only if a pop frees a slot.
  always_comb begin
    pop        = (cnt_q != '0) && dout_ready;
    full       = (cnt_q == CNT_FULL);
    wr_en      = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d      = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CNT_W'(1);
    overflow_d = overflow_q | drop;
    lost_cnt_d = (drop && lost_cnt_q != 16'hFFFF) ? lost_cnt_q + 16'd1 : lost_cnt_q;
  end

  // State and control registers; reset aborts any word in flight and drops the pads at once.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      phase_q    <= '0;
      cyc_q      <= '0;
      done_q     <= 1'b0;
      shreg_q    <= '0;
      read_q     <= 1'b0;
      freeze_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      lost_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      shreg_q    <= shreg_d;
      read_q     <= read_d;
      freeze_q   <= freeze_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  // FIFO storage.
  // NOTE: the array is deliberately not reset; dout is masked while empty instead.
  always_ff @(posedge clk_out) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_word;
  end

  assign read       = read_q;
  assign freeze     = freeze_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign lost_cnt   = lost_cnt_q;
  assign dout_valid = (cnt_q != '0);
  assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_monopix_readout_ctrl.sv
// Bench for monopix_readout_ctrl: a chip model serialises queued words when
// the readout enters SHIFT, stimulus pushes the expected words into
// scoreboards, and independent monitors pop and compare whatever the two
// instances (Gray-decoding and raw) present on their outputs.
module tb_monopix_readout_ctrl;

  localparam int W          = 27;
  localparam int SER_LAT    = 3;
  localparam int FREEZE_CLK = 20;   // (3 + 2) BX * 4 clk
  localparam int TW_CLK     = 12;   // 3 BX * 4 clk before READ
  localparam int READ_CLK   = 8;    // 2 BX * 4 clk
  localparam int VALID_CYC  = 31;   // SER_LAT + W + 1
  localparam int EXIT_CYC   = 32;   // first tick after push on cycle 30

  localparam logic [W-1:0] W1_RAW  = 27'h1234567;
  localparam logic [W-1:0] W1_DEC  = 27'h1227967;
  localparam logic [W-1:0] W2_RAW  = 27'h54040AA;  // le = 6'b100000
  localparam logic [W-1:0] W2_DEC  = 27'h5407EAA;  // le = 6'b111111
  localparam logic [W-1:0] T3A_RAW = 27'h0218001;
  localparam logic [W-1:0] T3A_DEC = 27'h0210001;
  localparam logic [W-1:0] T3B_RAW = 27'h0400602;
  localparam logic [W-1:0] T3B_DEC = 27'h0400402;
  localparam logic [W-1:0] T3C_RAW = 27'h07F8003;
  localparam logic [W-1:0] T3C_DEC = 27'h0750003;

  logic         clk_out, reset, enable, token, data_in, dout_ready;
  logic         read, freeze, dout_valid, busy, overflow;
  logic [W-1:0] dout;
  logic [15:0]  lost_cnt;
  logic         raw_read, raw_freeze, raw_valid, raw_busy, raw_ovf;
  logic [W-1:0] raw_dout;
  logic [15:0]  raw_lost;

  logic [W-1:0] chip_q [$];
  logic [W-1:0] exp_dec [$];
  logic [W-1:0] exp_raw [$];

  int n_checks = 0;
  int n_fail   = 0;
  logic track_busy   = 1'b0;
  logic busy_dropped = 1'b0;

  monopix_readout_ctrl #(.GRAY_DECODE(1)) dut (
    .clk_out(clk_out), .reset(reset), .enable(enable), .token(token), .data_in(data_in),
    .read(read), .freeze(freeze), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .overflow(overflow), .lost_cnt(lost_cnt)
  );

  monopix_readout_ctrl #(.GRAY_DECODE(0)) dut_raw (
    .clk_out(clk_out), .reset(reset), .enable(enable), .token(token), .data_in(data_in),
    .read(raw_read), .freeze(raw_freeze), .dout(raw_dout), .dout_valid(raw_valid),
    .dout_ready(dout_ready), .busy(raw_busy), .overflow(raw_ovf), .lost_cnt(raw_lost)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Chip model: on the first cycle after READ falls, shift the next queued word out MSB first.
  logic         read_prev = 1'b0;
  logic         shifting  = 1'b0;
  int           ser_c     = 0;
  logic [W-1:0] cur_word  = '0;
  initial data_in = 1'b0;
  always begin
    @(negedge clk_out);
    if (reset) begin
      shifting  = 1'b0;
      read_prev = 1'b0;
      data_in   = 1'b0;
    end else begin
      if (!shifting && read_prev && !read) begin
        cur_word = (chip_q.size() != 0) ? chip_q.pop_front() : '0;
        ser_c    = 0;
        shifting = 1'b1;
      end
      if (shifting) begin
        if (ser_c >= SER_LAT && ser_c < SER_LAT + W) data_in = cur_word[W-1-(ser_c-SER_LAT)];
        else                                         data_in = 1'b0;
        ser_c++;
        if (ser_c == SER_LAT + W) shifting = 1'b0;
      end else begin
        data_in = 1'b0;
      end
      read_prev = read;
    end
  end

  // Pad timing monitor: every freeze/read pulse must have the full width.
  int fcnt = 0;
  int rcnt = 0;
  always @(negedge clk_out) begin
    if (reset) begin
      fcnt = 0;
      rcnt = 0;
    end else begin
      if (read && rcnt == 0) check(fcnt == TW_CLK, "freeze_before_read", fcnt, TW_CLK);
      if (freeze) fcnt++;
      else if (fcnt != 0) begin
        check(fcnt == FREEZE_CLK, "freeze_width", fcnt, FREEZE_CLK);
        fcnt = 0;
      end
      if (read) rcnt++;
      else if (rcnt != 0) begin
        check(rcnt == READ_CLK, "read_width", rcnt, READ_CLK);
        rcnt = 0;
      end
    end
  end

  always @(negedge clk_out) if (track_busy && !busy) busy_dropped = 1'b1;

  // Scoreboard monitor, Gray-decoding instance.
  always begin
    logic         ok;
    logic [W-1:0] e;
    @(negedge clk_out);
    #1;
    if (!reset && dout_valid && dout_ready) begin
      ok = (exp_dec.size() != 0);
      e  = ok ? exp_dec.pop_front() : '0;
      check(ok && dout == e, "dec_word", 64'(dout), 64'(e));
    end
  end

  // Scoreboard monitor, raw instance.
  always begin
    logic         ok;
    logic [W-1:0] e;
    @(negedge clk_out);
    #1;
    if (!reset && raw_valid && dout_ready) begin
      ok = (exp_raw.size() != 0);
      e  = ok ? exp_raw.pop_front() : '0;
      check(ok && raw_dout == e, "raw_word", 64'(raw_dout), 64'(e));
    end
  end

  task automatic send(input logic [W-1:0] raw, input logic [W-1:0] dec, input bit kept);
    chip_q.push_back(raw);
    if (kept) begin
      exp_dec.push_back(dec);
      exp_raw.push_back(raw);
    end
  endtask

  task automatic pulse_token();
    token = 1'b1;
    repeat (4) @(negedge clk_out);
    token = 1'b0;
  endtask

  // Returns on the negedge of SHIFT cycle 0 (first cycle with read low after a read pulse).
  task automatic wait_shift_start(input string tag);
    int n = 0;
    while (!read && n < 400) begin @(negedge clk_out); n++; end
    while (read && n < 400)  begin @(negedge clk_out); n++; end
    check(n < 400, {tag, "_shift_timeout"}, n, 400);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin @(negedge clk_out); n++; end
    check(!busy, {tag, "_idle"}, 64'(busy), 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    dout_ready = 1'b1;
    while ((exp_dec.size() != 0 || exp_raw.size() != 0) && n < 100) begin
      @(negedge clk_out);
      n++;
    end
    @(negedge clk_out);
    check(exp_dec.size() == 0 && exp_raw.size() == 0, {tag, "_drained"},
          64'(exp_dec.size() + exp_raw.size()), 0);
  endtask

  initial begin
    int k;
    logic [W-1:0] wv;
    reset = 1'b1; enable = 1'b0; token = 1'b0; dout_ready = 1'b0;
    repeat (3) @(negedge clk_out);
    check(read == 1'b0,       "rst_read",     64'(read), 0);
    check(freeze == 1'b0,     "rst_freeze",   64'(freeze), 0);
    check(busy == 1'b0,       "rst_busy",     64'(busy), 0);
    check(dout_valid == 1'b0, "rst_valid",    64'(dout_valid), 0);
    check(overflow == 1'b0,   "rst_overflow", 64'(overflow), 0);
    check(lost_cnt == 16'd0,  "rst_lost",     64'(lost_cnt), 0);
    check(dout == '0,         "rst_dout",     64'(dout), 0);
    check(raw_read == 1'b0 && raw_freeze == 1'b0, "rst_raw_pads", 64'({raw_read, raw_freeze}), 0);
    reset = 1'b0;

    // T1: single hit, latency of dout_valid from SHIFT entry.
    enable = 1'b1; dout_ready = 1'b1;
    send(W1_RAW, W1_DEC, 1'b1);
    pulse_token();
    wait_shift_start("t1");
    k = 0;
    while (!dout_valid && k < 100) begin @(negedge clk_out); k++; end
    check(k == VALID_CYC, "t1_valid_latency", k, VALID_CYC);
    wait_idle("t1");
    drain("t1");

    // T2: Gray decode of le = 6'b100000.
    send(W2_RAW, W2_DEC, 1'b1);
    pulse_token();
    wait_shift_start("t2");
    wait_idle("t2");
    drain("t2");

    // T3: back-to-back words with token held, collected while the consumer stalls.
    dout_ready = 1'b0;
    send(T3A_RAW, T3A_DEC, 1'b1);
    send(T3B_RAW, T3B_DEC, 1'b1);
    send(T3C_RAW, T3C_DEC, 1'b1);
    token = 1'b1;
    wait_shift_start("t3");
    busy_dropped = 1'b0; track_busy = 1'b1;
    wait_shift_start("t3");
    wait_shift_start("t3");
    track_busy = 1'b0; token = 1'b0;
    check(busy_dropped == 1'b0, "t3_no_idle_between", 64'(busy_dropped), 0);
    wait_idle("t3");
    check(dout_valid && dout == T3A_DEC, "t3_head", 64'(dout), 64'(T3A_DEC));
    drain("t3");

    // T4: overflow with the consumer stalled, then push while full with a pop.
    dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wv = {6'(i + 4), 12'd0, 9'(i * 17 + 5)};
      send(wv, wv, i < 8);
    end
    token = 1'b1;
    wait_shift_start("t4");
    busy_dropped = 1'b0; track_busy = 1'b1;
    for (int i = 0; i < 9; i++) wait_shift_start("t4");
    track_busy = 1'b0; token = 1'b0;
    check(busy_dropped == 1'b0, "t4_no_idle_between", 64'(busy_dropped), 0);
    wait_idle("t4");
    check(overflow == 1'b1,  "t4_overflow", 64'(overflow), 1);
    check(lost_cnt == 16'd2, "t4_lost",     64'(lost_cnt), 2);
    check(raw_ovf == 1'b1 && raw_lost == 16'd2, "t4_raw_lost", 64'(raw_lost), 2);
    check(dout_valid == 1'b1, "t4_full_valid", 64'(dout_valid), 1);
    send(W1_RAW, W1_DEC, 1'b1);
    pulse_token();
    wait_shift_start("t4b");
    repeat (SER_LAT + W) @(negedge clk_out);
    dout_ready = 1'b1;
    @(negedge clk_out);
    dout_ready = 1'b0;
    check(lost_cnt == 16'd2, "t4_push_pop_lost", 64'(lost_cnt), 2);
    wait_idle("t4b");
    drain("t4");
    check(lost_cnt == 16'd2 && overflow == 1'b1, "t4_lost_sticky", 64'(lost_cnt), 2);

    // T5: reset in the middle of SHIFT, then a normal restart.
    dout_ready = 1'b1;
    send(27'h5A5A5A5, '0, 1'b0);
    pulse_token();
    wait_shift_start("t5");
    repeat (SER_LAT + 10) @(negedge clk_out);
    reset = 1'b1;
    #1;
    check(read == 1'b0 && freeze == 1'b0, "t5_pads_low", 64'({read, freeze}), 0);
    check(busy == 1'b0,       "t5_busy_low",  64'(busy), 0);
    check(dout_valid == 1'b0, "t5_valid_low", 64'(dout_valid), 0);
    check(lost_cnt == 16'd0 && overflow == 1'b0, "t5_counters_clear", 64'(lost_cnt), 0);
    @(negedge clk_out);
    @(negedge clk_out);
    reset = 1'b0;
    repeat (60) @(negedge clk_out);
    check(dout_valid == 1'b0 && raw_valid == 1'b0, "t5_no_partial", 64'({dout_valid, raw_valid}), 0);
    check(busy == 1'b0, "t5_stays_idle", 64'(busy), 0);
    send(W2_RAW, W2_DEC, 1'b1);
    pulse_token();
    wait_shift_start("t5b");
    wait_idle("t5b");
    drain("t5b");

    // T6: enable drops during READ with token still high.
    send(T3C_RAW, T3C_DEC, 1'b1);
    token = 1'b1;
    k = 0;
    while (!read && k < 200) begin @(negedge clk_out); k++; end
    check(read == 1'b1, "t6_read_seen", 64'(read), 1);
    enable = 1'b0;
    wait_shift_start("t6");
    k = 0;
    while (busy && k < 100) begin @(negedge clk_out); k++; end
    check(k == EXIT_CYC, "t6_busy_fall", k, EXIT_CYC);
    repeat (20) @(negedge clk_out);
    check(busy == 1'b0 && raw_busy == 1'b0, "t6_stays_idle", 64'({busy, raw_busy}), 0);
    token = 1'b0; enable = 1'b1;
    drain("t6");

    check(chip_q.size() == 0, "chip_words_consumed", 64'(chip_q.size()), 0);
    check(exp_dec.size() == 0 && exp_raw.size() == 0, "scoreboard_empty",
          64'(exp_dec.size() + exp_raw.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
